// File: rtl/tone_divider.sv
// -----------------------------------------------------------------------------
// tone_divider
//   Programmable audio-tone divider. It divides clk by a runtime divisor k and
//   produces a square wave with exactly 50% duty for both even and odd k. Odd
//   divisors get their extra half cycle from a negedge copy of the posedge
//   phase bit. A divisor below 2 silences the output.
//
// Ports:
//   clk    : system clock; both edges are used internally
//   rst    : asynchronous, active-high reset; forces clkout low at once
//   k      : divide factor; output period is k clk cycles; k < 2 means off
//   clkout : divided tone output
// -----------------------------------------------------------------------------
module tone_divider #(
   parameter int WIDTH = 13
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] k,
   output logic             clkout
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

   logic [WIDTH-1:0] k_q, k_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             pos_q, pos_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] half;

   always_comb begin
      // ceil(k_q/2) written so it cannot overflow at the maximum divisor
      half  = (k_q >> 1) + {{(WIDTH-1){1'b0}}, k_q[0]};
      k_d   = k_q;
      cnt_d = cnt_q;
      pos_d = pos_q;
      if (k != k_q) begin
         // New divisor: abandon the running period. Loading k-1 makes the
         // very next posedge wrap to 0 and start a fresh high phase.
         k_d   = k;
         cnt_d = (k < TWO) ? '0 : k - ONE;
         pos_d = 1'b0;
      end else if (k_q < TWO) begin
         cnt_d = '0;
         pos_d = 1'b0;
      end else begin
         cnt_d = (cnt_q == k_q - ONE) ? '0 : cnt_q + ONE;
         pos_d = (cnt_d < half);
      end
   end

   // Half-cycle delayed copy of the posedge phase bit.
   always_comb begin
      neg_d = pos_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q   <= '0;
         cnt_q <= '0;
         pos_q <= 1'b0;
      end else begin
         k_q   <= k_d;
         cnt_q <= cnt_d;
         pos_q <= pos_d;
      end
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         neg_q <= 1'b0;
      end else begin
         neg_q <= neg_d;
      end
   end

   // For odd divisors the AND trims the high phase by half a cycle at its
   // start, and the low phase gains it. pos_q and neg_q never change on the
   // same edge, so the output cannot glitch.
   assign clkout = k_q[0] ? (pos_q & neg_q) : pos_q;

endmodule

// File: tb/tb_tone_divider.sv
// -----------------------------------------------------------------------------
// tb_tone_divider
//   Directed bench for tone_divider. Waveform phases are measured in
//   half-cycles of clk by sampling clkout 1 ns after every clk edge.
// -----------------------------------------------------------------------------
module tb_tone_divider;

   localparam int WIDTH = 13;
   localparam int LIMIT = 20000;   // half-cycle budget for any single wait

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] k;
   logic             clkout;

   int checks = 0;
   int errors = 0;

   logic s;    // clkout at the latest sample
   logic sc;   // clk level at the latest sample (1: just after a posedge)

   tone_divider #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .k      (k),
      .clkout (clkout)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk or negedge clk);
      #1;
      s  = clkout;
      sc = clk;
   endtask

   // Counts consecutive samples equal to val, the current one included.
   task automatic count_run(input logic val, output int n);
      n = 1;
      for (int i = 0; i < LIMIT; i++) begin
         step();
         if (s != val) return;
         n++;
      end
      check_eq("run_timeout", 0, 1);
   endtask

   // Waits for a rising clkout, then measures one high and one low phase.
   task automatic measure(output int hi, output int lo,
                          output logic rise_clk, output logic fall_clk);
      logic prev;
      bit   found;
      found    = 1'b0;
      hi       = 0;
      lo       = 0;
      rise_clk = 1'b0;
      fall_clk = 1'b0;
      s        = clkout;
      for (int i = 0; i < LIMIT && !found; i++) begin
         prev = s;
         step();
         if (prev == 1'b0 && s == 1'b1) found = 1'b1;
      end
      if (!found) begin
         check_eq("rise_timeout", 0, 1);
         return;
      end
      rise_clk = sc;
      count_run(1'b1, hi);
      fall_clk = sc;
      count_run(1'b0, lo);
   endtask

   task automatic check_wave(input string tag, input int kval, input logic odd);
      int   hi, lo;
      logic rc, fc;
      @(negedge clk);
      k = WIDTH'(kval);
      measure(hi, lo, rc, fc);
      check_eq({tag, "_high_halves"}, hi, kval);
      check_eq({tag, "_low_halves"}, lo, kval);
      // odd: rise just after a negedge, fall just after a posedge
      check_eq({tag, "_rise_on_posedge"}, int'(rc), odd ? 0 : 1);
      check_eq({tag, "_fall_on_posedge"}, int'(fc), 1);
   endtask

   task automatic check_silent(input string tag, input int kval);
      int highs;
      @(negedge clk);
      k = WIDTH'(kval);
      @(posedge clk);
      #1;
      check_eq({tag, "_low_in_1cyc"}, int'(clkout), 0);
      highs = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (s) highs++;
      end
      check_eq({tag, "_high_samples"}, highs, 0);
   endtask

   initial begin
      int hi, lo;
      int n_bad;

      // reset with a live divisor on the input
      rst = 1'b1;
      k   = 13'd3817;
      #2;
      check_eq("rst_async_low", int'(clkout), 0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_held_low", int'(clkout), 0);

      // even divisor: first rise at the 2nd posedge after k is applied
      @(negedge clk);
      rst = 1'b0;
      k   = 13'd3400;
      @(posedge clk);
      #1;
      check_eq("even_p0_low", int'(clkout), 0);
      @(posedge clk);
      #1;
      check_eq("even_p1_high", int'(clkout), 1);
      check_wave("k3400", 3400, 1'b0);

      // odd divisors
      check_wave("k3817", 3817, 1'b1);

      // async reset in the middle of a high phase
      @(posedge clk);
      #2;
      check_eq("pre_rst_high", int'(clkout), 1);
      rst = 1'b1;
      #1;
      check_eq("rst_mid_high_low", int'(clkout), 0);
      @(negedge clk);
      rst = 1'b0;

      check_wave("k3", 3, 1'b1);

      // silence and minimum
      check_silent("k0", 0);
      check_silent("k1", 1);
      check_wave("k2", 2, 1'b0);

      // divisor switch in the middle of a high phase
      @(negedge clk);
      k = 13'd2551;
      measure(hi, lo, sc, sc);
      repeat (100) @(posedge clk);
      #1;
      check_eq("sw_in_high", int'(clkout), 1);
      @(negedge clk);
      k = 13'd2272;
      @(posedge clk);
      #1;
      check_eq("sw_p0_low", int'(clkout), 0);
      @(posedge clk);
      #1;
      check_eq("sw_p1_high", int'(clkout), 1);
      s = clkout;
      count_run(1'b1, hi);
      count_run(1'b0, lo);
      check_eq("sw_first_high_halves", hi, 2272);
      check_eq("sw_first_low_halves", lo, 2272);

      // stability: ten consecutive periods of k=1911
      @(negedge clk);
      k = 13'd1911;
      measure(hi, lo, sc, sc);
      n_bad = 0;
      for (int p = 0; p < 10; p++) begin
         count_run(1'b1, hi);
         count_run(1'b0, lo);
         if (hi != 1911 || lo != 1911) n_bad++;
      end
      check_eq("k1911_bad_periods", n_bad, 0);

      // maximum divisor
      check_wave("k8191", 8191, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
